// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader for the MIPS32 core: assembles big-endian
// words from a framed stream, writes them to memory and releases the core.
module mips32_prog_loader #(
   parameter int          ADDR_W    = 10,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              core_start,
   output logic              load_err,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_WRITE,
      S_CSUM
   } state_t;

   state_t      state;
   logic [7:0]  hi_byte;
   logic [15:0] addr;
   logic [15:0] remain;
   logic [23:0] word;
   logic [1:0]  bidx;
   logic [7:0]  csum;
   logic        acc;

   assign acc = in_valid & in_ready;

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         in_ready   <= 1'b1;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_hold  <= 1'b1;
         core_start <= 1'b0;
         load_err   <= 1'b0;
         busy       <= 1'b0;
         hi_byte    <= '0;
         addr       <= '0;
         remain     <= '0;
         word       <= '0;
         bidx       <= '0;
         csum       <= '0;
      end else begin
         mem_we     <= 1'b0;
         core_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (acc && in_data == SYNC_BYTE) begin
                  state     <= S_ADDR_HI;
                  busy      <= 1'b1;
                  core_hold <= 1'b1;
                  load_err  <= 1'b0;
                  csum      <= '0;
                  bidx      <= '0;
               end
            end
            S_ADDR_HI: begin
               if (acc) begin
                  hi_byte <= in_data;
                  state   <= S_ADDR_LO;
               end
            end
            S_ADDR_LO: begin
               if (acc) begin
                  addr  <= {hi_byte, in_data};
                  state <= S_CNT_HI;
               end
            end
            S_CNT_HI: begin
               if (acc) begin
                  hi_byte <= in_data;
                  state   <= S_CNT_LO;
               end
            end
            S_CNT_LO: begin
               if (acc) begin
                  remain <= {hi_byte, in_data};
                  if ({hi_byte, in_data} == 16'd0)
                     state <= S_CSUM;
                  else
                     state <= S_DATA;
               end
            end
            S_DATA: begin
               if (acc) begin
                  csum <= csum ^ in_data;
                  word <= {word[15:0], in_data};
                  bidx <= bidx + 2'd1;
                  if (bidx == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= addr[ADDR_W-1:0];
                     mem_wdata <= {word, in_data};
                     in_ready  <= 1'b0;
                     state     <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               // low ADDR_W bits of the 16-bit pointer give the wrap
               addr     <= addr + 16'd1;
               remain   <= remain - 16'd1;
               in_ready <= 1'b1;
               if (remain == 16'd1)
                  state <= S_CSUM;
               else
                  state <= S_DATA;
            end
            S_CSUM: begin
               if (acc) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
                  if (in_data == csum) begin
                     core_start <= 1'b1;
                     core_hold  <= 1'b0;
                  end else begin
                     load_err <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: frame-level model of expected
// writes and start pulses, checked every cycle.
module tb_mips32_prog_loader;

   localparam int ADDR_W = 10;

   logic              clk1 = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_hold;
   logic              core_start;
   logic              load_err;
   logic              busy;

   mips32_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
      .clk1(clk1), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_hold(core_hold), .core_start(core_start),
      .load_err(load_err), .busy(busy)
   );

   always #5 clk1 = ~clk1;

   int checks = 0;
   int errors = 0;
   int starts = 0;
   int wr_cnt = 0;
   bit mon_en = 1'b0;

   logic [7:0]  bytes [$];
   logic [31:0] wq [$];
   int          exp_a [$];
   logic [31:0] exp_d [$];
   logic [31:0] mem [0:1023];
   logic [7:0]  last_cs;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Per-cycle monitor against the frame model
   always @(negedge clk1) begin
      if (mon_en && rst_n) begin
         checks++;
         if (in_ready !== !mem_we) begin
            errors++;
            $display("FAIL ready_vs_we: in_ready %b mem_we %b", in_ready, mem_we);
         end
         if (mem_we) begin
            wr_cnt++;
            mem[mem_addr] = mem_wdata;
            checks++;
            if (exp_a.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr %h data %h expected none",
                        mem_addr, mem_wdata);
            end else begin
               int          ea;
               logic [31:0] ed;
               ea = exp_a.pop_front();
               ed = exp_d.pop_front();
               if (int'(mem_addr) != ea || mem_wdata !== ed) begin
                  errors++;
                  $display("FAIL write: got %h/%h expected %h/%h",
                           mem_addr, mem_wdata, ea[ADDR_W-1:0], ed);
               end
            end
         end
         if (core_start) begin
            starts++;
            checks++;
            if (core_hold !== 1'b0) begin
               errors++;
               $display("FAIL start_hold: core_hold %b expected 0", core_hold);
            end
         end
      end
   end

   task automatic build_frame(input logic [15:0] a, input bit bad);
      logic [15:0] n;
      logic [7:0]  cs;
      n  = 16'(wq.size());
      cs = 8'h00;
      bytes.push_back(8'hA5);
      bytes.push_back(a[15:8]);
      bytes.push_back(a[7:0]);
      bytes.push_back(n[15:8]);
      bytes.push_back(n[7:0]);
      foreach (wq[i]) begin
         logic [31:0] w;
         w = wq[i];
         for (int b = 3; b >= 0; b--) begin
            bytes.push_back(w[b*8 +: 8]);
            cs ^= w[b*8 +: 8];
         end
         exp_a.push_back((int'(a[ADDR_W-1:0]) + i) % 1024);
         exp_d.push_back(w);
      end
      last_cs = cs;
      bytes.push_back(bad ? ~cs : cs);
      wq.delete();
   endtask

   // Holds in_valid high; a byte advances only when accepted
   task automatic send_bytes();
      int idx;
      int budget;
      logic r;
      idx    = 0;
      budget = 0;
      while (idx < bytes.size() && budget < 2000) begin
         @(negedge clk1);
         in_valid = 1'b1;
         in_data  = bytes[idx];
         r = in_ready;
         @(posedge clk1);
         if (r) idx++;
         budget++;
      end
      if (idx < bytes.size()) begin
         errors++;
         $display("FAIL send_timeout: sent %0d expected %0d", idx, bytes.size());
      end
      @(negedge clk1);
      in_valid = 1'b0;
      bytes.delete();
   endtask

   task automatic frame_end(input string tag, input int exp_starts,
                            input logic exp_hold, input logic exp_err);
      repeat (3) @(negedge clk1);
      chk({tag, "_pending"}, 32'(exp_a.size()), 32'd0);
      chk({tag, "_starts"}, 32'(starts), 32'(exp_starts));
      chk({tag, "_hold"}, 32'(core_hold), 32'(exp_hold));
      chk({tag, "_err"}, 32'(load_err), 32'(exp_err));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk1);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_hold", 32'(core_hold), 32'd1);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_start", 32'(core_start), 32'd0);
      chk("rst_err", 32'(load_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Good program frame
      wq = '{32'h28010078, 32'h0C631800, 32'h20220000, 32'h0C631800,
             32'h2842002D, 32'h0C631800, 32'h24220001, 32'hFC000000};
      build_frame(16'h0000, 1'b0);
      send_bytes();
      frame_end("good", 1, 1'b0, 1'b0);
      chk("good_writes", 32'(wr_cnt), 32'd8);
      chk("good_mem0", mem[0], 32'h28010078);
      chk("good_mem7", mem[7], 32'hFC000000);

      // Same frame, corrupted checksum
      wq = '{32'h28010078, 32'h0C631800, 32'h20220000, 32'h0C631800,
             32'h2842002D, 32'h0C631800, 32'h24220001, 32'hFC000000};
      build_frame(16'h0000, 1'b1);
      send_bytes();
      frame_end("bad", 1, 1'b1, 1'b1);
      chk("bad_writes", 32'(wr_cnt), 32'd16);

      // Address wrap at the top of memory
      wq = '{32'h11223344, 32'h55667788};
      build_frame(16'h03FF, 1'b0);
      chk("wrap_csum_model", 32'(last_cs), 32'h88);
      send_bytes();
      frame_end("wrap", 2, 1'b0, 1'b0);
      chk("wrap_mem3ff", mem[10'h3FF], 32'h11223344);
      chk("wrap_mem000", mem[0], 32'h55667788);

      // Garbage then an empty frame
      bytes.push_back(8'h00);
      bytes.push_back(8'hFF);
      build_frame(16'h0010, 1'b0);
      send_bytes();
      frame_end("empty", 3, 1'b0, 1'b0);
      chk("empty_writes", 32'(wr_cnt), 32'd18);

      // Reset after two data bytes of a partial word
      bytes = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'hDE, 8'hAD};
      send_bytes();
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk1);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_hold", 32'(core_hold), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_we", 32'(mem_we), 32'd0);
      rst_n = 1'b1;
      wq = '{32'hCAFEF00D, 32'h0BADBEEF};
      build_frame(16'h0020, 1'b0);
      send_bytes();
      frame_end("reload", 4, 1'b0, 1'b0);
      chk("reload_writes", 32'(wr_cnt), 32'd20);
      chk("reload_mem20", mem[10'h020], 32'hCAFEF00D);
      chk("reload_mem21", mem[10'h021], 32'h0BADBEEF);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
